lsu_mem_access: RTL and testbench



---
 rtl/lsu_mem_access.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_access.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access.sv
// Load/store unit: issues one doubleword-aligned bus access at a time and returns
// lane-shifted, zero- or sign-extended load data to writeback.
module lsu_mem_access #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              MemWr,
  input  logic [2:0]        MemOP,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsuState_e;

  lsuState_e   stateQ;
  logic [2:0]  memOpQ;
  logic [2:0]  offsetQ;
  logic        isStoreQ;

  logic [7:0]        baseMask;
  logic              badAccess;
  logic [7:0]        storeMask;
  logic [DATA_W-1:0] storeData;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] loadVal;
  logic              sgn;

  // Request-side decode straight from the EX inputs, used on the accepting cycle.
  always_comb begin
    baseMask  = 8'h00;
    badAccess = 1'b0;
    case (MemOP[1:0])
      2'b00: begin
        baseMask  = {8{MemOP[2]}};
        badAccess = !MemOP[2] || (addr[2:0] != 3'b000);
      end
      2'b01: begin
        baseMask  = 8'h0F;
        badAccess = (addr[1:0] != 2'b00);
      end
      2'b10: begin
        baseMask  = 8'h03;
        badAccess = addr[0];
      end
      default: begin
        baseMask  = 8'h01;
        badAccess = 1'b0;
      end
    endcase
    storeMask = baseMask << addr[2:0];
    storeData = wdata << {addr[2:0], 3'b000};
  end

  // Load extraction uses the latched size/offset, since addr may change after acceptance.
  always_comb begin
    shifted = mem_rdata >> {offsetQ, 3'b000};
    sgn     = memOpQ[2] && (memOpQ[1:0] != 2'b00);
    case (memOpQ[1:0])
      2'b01:   loadVal = {{32{sgn & shifted[31]}}, shifted[31:0]};
      2'b10:   loadVal = {{48{sgn & shifted[15]}}, shifted[15:0]};
      2'b11:   loadVal = {{56{sgn & shifted[7]}}, shifted[7:0]};
      default: loadVal = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ        <= StIdle;
      memOpQ        <= 3'b000;
      offsetQ       <= 3'b000;
      isStoreQ      <= 1'b0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      rdata         <= '0;
      misalign      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wmask     <= 8'h00;
      mem_wdata     <= '0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (in_valid) begin
            memOpQ   <= MemOP;
            isStoreQ <= MemWr;
            offsetQ  <= addr[2:0];
            in_ready <= 1'b0;
            if (badAccess) begin
              misalign  <= 1'b1;
              rdata     <= '0;
              out_valid <= 1'b1;
              stateQ    <= StDone;
            end else begin
              mem_req_valid <= 1'b1;
              mem_addr      <= {addr[ADDR_W-1:3], 3'b000};
              mem_wen       <= MemWr;
              mem_wmask     <= MemWr ? storeMask : 8'hFF;
              mem_wdata     <= MemWr ? storeData : '0;
              stateQ        <= StReq;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            stateQ        <= StWait;
          end
        end
        StWait: begin
          if (mem_rsp_valid) begin
            rdata     <= isStoreQ ? '0 : loadVal;
            out_valid <= 1'b1;
            stateQ    <= StDone;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            misalign  <= 1'b0;
            in_ready  <= 1'b1;
            stateQ    <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed test-plan accesses, then randomized accesses checked
// against a byte-lane reference model.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        MemWr;
  logic [2:0]  MemOP;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rdata;
  logic        misalign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;

  int compared = 0;
  int mismatched = 0;

  lsu_mem_access #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .MemWr(MemWr),
    .MemOP(MemOP), .addr(addr), .wdata(wdata), .out_valid(out_valid), .out_ready(out_ready),
    .rdata(rdata), .misalign(misalign), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for the "none" encoding.
  function automatic int sizeOf(input logic [2:0] op);
    if (op == 3'b100) return 8;
    if (op == 3'b000) return 0;
    if (op == 3'b001 || op == 3'b101) return 4;
    if (op == 3'b010 || op == 3'b110) return 2;
    return 1;
  endfunction

  function automatic bit isBad(input logic [2:0] op, input logic [63:0] a);
    int sz = sizeOf(op);
    return (sz == 0) || ((a % sz) != 0);
  endfunction

  function automatic logic [7:0] expMask(input bit wr, input logic [2:0] op,
                                         input logic [63:0] a);
    logic [7:0] m = 8'h00;
    int off = int'(a[2:0]);
    if (!wr) return 8'hFF;
    for (int b = 0; b < 8; b++) m[b] = (b >= off) && (b < off + sizeOf(op));
    return m;
  endfunction

  function automatic logic [63:0] expWdata(input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] v = '0;
    int off = int'(a[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off) v[8*b +: 8] = wd[8*(b-off) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] expLoad(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] bus);
    logic [63:0] v = '0;
    int sz = sizeOf(op);
    int off = int'(a[2:0]);
    bit neg;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = bus[8*(off+i) +: 8];
    neg = (op == 3'b101 || op == 3'b110 || op == 3'b111) && bus[8*(off+sz)-1];
    if (neg) for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Full transaction, all driving and sampling on negative edges.
  task automatic doAccess(input bit wr, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] bus,
                          input int stall, input int rspDly, input int outHold);
    logic [63:0] expR;
    @(negedge clk);
    chk("in_ready idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; MemWr = wr; MemOP = op; addr = a; wdata = wd;
    @(negedge clk);
    in_valid = 1'b0; addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (isBad(op, a)) begin
      chk("misalign req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("misalign out_valid", {63'd0, out_valid}, 64'd1);
      chk("misalign flag", {63'd0, misalign}, 64'd1);
      chk("misalign rdata", rdata, 64'd0);
      expR = 64'd0;
    end else begin
      chk("req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("mem_addr", mem_addr, {a[63:3], 3'b000});
      chk("mem_wen", {63'd0, mem_wen}, {63'd0, wr});
      chk("mem_wmask", {56'd0, mem_wmask}, {56'd0, expMask(wr, op, a)});
      if (wr) chk("mem_wdata", mem_wdata, expWdata(a, wd));
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall req_valid", {63'd0, mem_req_valid}, 64'd1);
        chk("stall mem_addr", mem_addr, {a[63:3], 3'b000});
        chk("stall mem_wmask", {56'd0, mem_wmask}, {56'd0, expMask(wr, op, a)});
        if (wr) chk("stall mem_wdata", mem_wdata, expWdata(a, wd));
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("req_valid dropped", {63'd0, mem_req_valid}, 64'd0);
      for (int i = 0; i < rspDly; i++) begin
        @(negedge clk);
        chk("wait no out_valid", {63'd0, out_valid}, 64'd0);
      end
      mem_rsp_valid = 1'b1; mem_rdata = bus;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rdata = {$urandom, $urandom};
      expR = wr ? 64'd0 : expLoad(op, a, bus);
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("misalign clear", {63'd0, misalign}, 64'd0);
      chk("rdata", rdata, expR);
    end
    for (int i = 0; i < outHold; i++) begin
      @(negedge clk);
      chk("hold out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold rdata", rdata, expR);
      chk("hold in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("released out_valid", {63'd0, out_valid}, 64'd0);
    chk("released misalign", {63'd0, misalign}, 64'd0);
    chk("released in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [2:0]  opTab [8];
    logic [2:0]  op;
    logic [63:0] a;
    bit          wr;
    opTab = '{3'b100, 3'b101, 3'b001, 3'b110, 3'b010, 3'b111, 3'b011, 3'b000};
    rst = 1'b1; in_valid = 1'b0; MemWr = 1'b0; MemOP = 3'b000; addr = '0; wdata = '0;
    out_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("reset rdata", rdata, 64'd0);
    chk("reset wmask", {56'd0, mem_wmask}, 64'd0);

    // Test-plan accesses.
    doAccess(1'b0, 3'b100, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 5, 0, 3);
    doAccess(1'b0, 3'b111, 64'h8000_0005, 64'd0, 64'h0000_F000_0000_0000, 0, 0, 0);
    doAccess(1'b0, 3'b011, 64'h8000_0005, 64'd0, 64'h0000_F000_0000_0000, 0, 1, 0);
    doAccess(1'b0, 3'b101, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 0, 0, 0);
    doAccess(1'b0, 3'b001, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 1, 0, 0);
    doAccess(1'b1, 3'b010, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'h0, 0, 2, 1);
    doAccess(1'b0, 3'b101, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 2);
    doAccess(1'b0, 3'b000, 64'h8000_0000, 64'd0, 64'd0, 0, 0, 0);

    // Reset while waiting for the response; the stale response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; MemWr = 1'b0; MemOP = 3'b100; addr = 64'h8000_0040;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst req_valid", {63'd0, mem_req_valid}, 64'd0);
    mem_rsp_valid = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stale rsp out_valid", {63'd0, out_valid}, 64'd0);
      chk("stale rsp in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
    end

    // Reset while the bus request is pending drops mem_req_valid.
    in_valid = 1'b1; MemWr = 1'b1; MemOP = 3'b011; addr = 64'h8000_0003;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-rst req_valid", {63'd0, mem_req_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst req drop", {63'd0, mem_req_valid}, 64'd0);
    chk("rst req in_ready", {63'd0, in_ready}, 64'd1);

    // Randomized accesses, biased toward aligned addresses.
    for (int n = 0; n < 40; n++) begin
      op = opTab[$urandom_range(0, 7)];
      wr = ($urandom_range(0, 2) == 0) && (op[2] == 1'b0 || op == 3'b100);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~(3'(sizeOf(op)) - 3'd1);
      doAccess(wr, op, a, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
